// File: rtl/kernel_job_scheduler.sv
// Job queue plus round-robin dispatcher: buffers job ids and issues each one to
// the next idle kernel, tracking per-kernel busy and completion status.
module kernel_job_scheduler #(
  parameter int KERNEL_NUM = 8,
  parameter int JOB_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sched_enable,
  input  logic                          job_valid,
  input  logic [JOB_W-1:0]              job_id,
  output logic                          job_ready,
  output logic [KERNEL_NUM-1:0]         kernel_start,
  output logic [JOB_W-1:0]              kernel_job_id,
  input  logic [KERNEL_NUM-1:0]         kernel_done,
  output logic [KERNEL_NUM-1:0]         kernel_busy,
  output logic [KERNEL_NUM-1:0]         kernel_complete,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int KW = $clog2(KERNEL_NUM);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  // Handshake: a job is taken on any rising edge where job_valid and job_ready
  // are both high; job_ready depends only on the registered queue count.

  state_e                  state_q, state_d;
  logic [JOB_W-1:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic [KERNEL_NUM-1:0]   busy_q, busy_d;
  logic [KERNEL_NUM-1:0]   complete_q, complete_d;
  logic [KERNEL_NUM-1:0]   start_q;
  logic [JOB_W-1:0]        job_id_q;
  logic [KW-1:0]           last_grant_q;

  logic                    push, issue, fifo_empty, grant_found;
  logic [KW-1:0]           grant_idx;
  logic [KERNEL_NUM-1:0]   grant_oh;
  int                      idx;

  assign job_ready       = (count_q < CW'(FIFO_DEPTH));
  assign fifo_empty      = (count_q == '0);
  assign push            = job_valid & job_ready;
  assign kernel_start    = start_q;
  assign kernel_job_id   = job_id_q;
  assign kernel_busy     = busy_q;
  assign kernel_complete = complete_q;
  assign fifo_count      = count_q;
  assign dbg_state       = state_q;

  // Round-robin search starting one past the last granted kernel.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 1; i <= KERNEL_NUM; i++) begin
      idx = int'(last_grant_q) + i;
      if (idx >= KERNEL_NUM) idx = idx - KERNEL_NUM;
      if (!grant_found && !busy_q[KW'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = KW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && sched_enable) state_d = S_ARB;
      end
      S_ARB: begin
        if (!sched_enable || fifo_empty) begin
          state_d = S_IDLE;
        end else if (grant_found) begin
          state_d = S_ISSUE;
          issue   = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = (!fifo_empty && sched_enable) ? S_ARB : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The start pulse is registered, so it is visible exactly while in ISSUE.
  always_comb begin
    grant_oh = '0;
    if (issue) grant_oh[grant_idx] = 1'b1;
    count_d    = count_q + CW'(push) - CW'(issue);
    busy_d     = (busy_q & ~kernel_done) | grant_oh;
    complete_d = (complete_q | (kernel_done & busy_q)) & ~grant_oh;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= job_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      busy_q       <= '0;
      complete_q   <= '0;
      start_q      <= '0;
      job_id_q     <= '0;
      last_grant_q <= KW'(KERNEL_NUM - 1);
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      complete_q <= complete_d;
      start_q    <= grant_oh;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (issue) begin
        rd_ptr_q     <= rd_ptr_q + PW'(1);
        job_id_q     <= mem_q[rd_ptr_q];
        last_grant_q <= grant_idx;
      end else begin
        job_id_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_kernel_job_scheduler.sv
// Scenario bench for kernel_job_scheduler: expected (start, job id) pairs are
// queued when jobs are offered and checked whenever a start pulse appears.
module tb_kernel_job_scheduler;

  localparam int K  = 8;
  localparam int JW = 16;
  localparam int FD = 4;
  localparam int W  = K + JW;

  logic              clk;
  logic              rst_n;
  logic              sched_enable;
  logic              job_valid;
  logic [JW-1:0]     job_id;
  logic              job_ready;
  logic [K-1:0]      kernel_start;
  logic [JW-1:0]     kernel_job_id;
  logic [K-1:0]      kernel_done;
  logic [K-1:0]      kernel_busy;
  logic [K-1:0]      kernel_complete;
  logic [2:0]        fifo_count;
  logic [1:0]        dbg_state;

  logic [W-1:0]      exp_q[$];
  int                tests;
  int                fails;

  kernel_job_scheduler #(.KERNEL_NUM(K), .JOB_W(JW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .sched_enable(sched_enable),
    .job_valid(job_valid), .job_id(job_id), .job_ready(job_ready),
    .kernel_start(kernel_start), .kernel_job_id(kernel_job_id),
    .kernel_done(kernel_done), .kernel_busy(kernel_busy),
    .kernel_complete(kernel_complete), .fifo_count(fifo_count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor: every start pulse must match the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (kernel_start != '0) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_start: got start=%h id=%h, required none", kernel_start, kernel_job_id);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if ({kernel_start, kernel_job_id} !== e) begin
            fails++;
            $display("FAIL dispatch: got start=%h id=%h, required start=%h id=%h",
                     kernel_start, kernel_job_id, e[W-1:JW], e[JW-1:0]);
          end
        end
      end else if (kernel_job_id !== '0) begin
        tests++;
        fails++;
        $display("FAIL idle_job_id: got %h, required 0", kernel_job_id);
      end
    end
  end

  // driver tasks (called at a falling edge)
  task automatic apply_reset();
    rst_n = 1'b0;
    sched_enable = 1'b0;
    job_valid = 1'b0;
    job_id = '0;
    kernel_done = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_job(input logic [JW-1:0] id);
    int t;
    job_valid = 1'b1;
    job_id = id;
    t = 0;
    while (!job_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (t >= 100) begin
      fails++;
      $display("FAIL push_timeout: job_ready stayed %b, required 1", job_ready);
    end
    @(negedge clk);
    job_valid = 1'b0;
    job_id = '0;
  endtask

  task automatic expect_start(input logic [K-1:0] k, input logic [JW-1:0] id);
    exp_q.push_back({k, id});
  endtask

  task automatic pulse_done(input logic [K-1:0] d);
    kernel_done = d;
    @(negedge clk);
    kernel_done = '0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d starts outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_vec(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    sched_enable = 1'b0;
    job_valid = 1'b0;
    job_id = '0;
    kernel_done = '0;
    repeat (2) @(negedge clk);
    check_vec("reset_ready", 32'(job_ready), 32'd1);
    check_vec("reset_start", 32'(kernel_start), 32'd0);
    check_vec("reset_job_id", 32'(kernel_job_id), 32'd0);
    check_vec("reset_busy", 32'(kernel_busy), 32'd0);
    check_vec("reset_complete", 32'(kernel_complete), 32'd0);
    check_vec("reset_count", 32'(fifo_count), 32'd0);
    check_vec("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    apply_reset();
    sched_enable = 1'b1;
    expect_start(8'h01, 16'h0011);
    push_job(16'h0011);
    @(negedge clk);
    check_vec("single_no_early_start", 32'(kernel_start), 32'd0);
    @(negedge clk);
    check_vec("single_start", 32'(kernel_start), 32'h01);
    check_vec("single_id", 32'(kernel_job_id), 32'h0011);
    check_vec("single_busy", 32'(kernel_busy), 32'h01);
    wait_drain();
    pulse_done(8'h01);
    check_vec("single_complete", 32'(kernel_complete), 32'h01);
    check_vec("single_busy_clear", 32'(kernel_busy), 32'h00);
  endtask

  task automatic test_back_to_back();
    logic [JW-1:0] ids [9];
    apply_reset();
    sched_enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ids[i] = JW'($urandom_range(1, 16'hffff));
      if (i < 8) expect_start(K'(1) << i, ids[i]);
    end
    for (int i = 0; i < 9; i++) push_job(ids[i]);
    repeat (30) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check_vec("b2b_all_started", 32'(exp_q.size()), 32'd0);
    check_vec("b2b_busy_all", 32'(kernel_busy), 32'hff);
    check_vec("b2b_count", 32'(fifo_count), 32'd1);
    expect_start(8'h08, ids[8]);
    pulse_done(8'h08);
    check_vec("b2b_complete3", 32'(kernel_complete), 32'h08);
    wait_drain();
    check_vec("b2b_complete_cleared", 32'(kernel_complete), 32'h00);
    check_vec("b2b_busy_after", 32'(kernel_busy), 32'hff);
    check_vec("b2b_count_after", 32'(fifo_count), 32'd0);
  endtask

  task automatic test_fifo_full();
    apply_reset();
    sched_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_start(K'(1) << i, JW'(16'h0100 + i));
      push_job(JW'(16'h0100 + i));
    end
    wait_drain();
    for (int i = 0; i < 4; i++) push_job(JW'(16'h0200 + i));
    repeat (2) @(negedge clk);
    check_vec("full_count", 32'(fifo_count), 32'd4);
    check_vec("full_ready", 32'(job_ready), 32'd0);
    job_valid = 1'b1;
    job_id = 16'hdead;
    repeat (3) @(negedge clk);
    job_valid = 1'b0;
    job_id = '0;
    check_vec("full_count_hold", 32'(fifo_count), 32'd4);
  endtask

  task automatic test_multi_done();
    apply_reset();
    sched_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_start(K'(1) << i, JW'(16'h0300 + i));
      push_job(JW'(16'h0300 + i));
    end
    wait_drain();
    check_vec("multi_busy_pre", 32'(kernel_busy), 32'h07);
    pulse_done(8'h05);
    check_vec("multi_complete", 32'(kernel_complete), 32'h05);
    check_vec("multi_busy", 32'(kernel_busy), 32'h02);
    pulse_done(8'h80);
    check_vec("idle_done_complete", 32'(kernel_complete), 32'h05);
    check_vec("idle_done_busy", 32'(kernel_busy), 32'h02);
  endtask

  task automatic test_enable_gate();
    apply_reset();
    sched_enable = 1'b1;
    expect_start(8'h01, 16'h0400);
    push_job(16'h0400);
    wait_drain();
    sched_enable = 1'b0;
    push_job(16'h0401);
    push_job(16'h0402);
    repeat (8) @(negedge clk);
    check_vec("gate_count", 32'(fifo_count), 32'd2);
    check_vec("gate_state_idle", 32'(dbg_state), 32'd0);
    expect_start(8'h02, 16'h0401);
    expect_start(8'h04, 16'h0402);
    sched_enable = 1'b1;
    wait_drain();
    check_vec("gate_busy", 32'(kernel_busy), 32'h07);
    check_vec("gate_count_after", 32'(fifo_count), 32'd0);
  endtask

  task automatic test_reset_busy();
    pulse_done(8'h02);
    sched_enable = 1'b0;
    push_job(16'h0500);
    check_vec("rb_pre_count", 32'(fifo_count), 32'd1);
    check_vec("rb_pre_busy", 32'(kernel_busy), 32'h05);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("rb_async_busy", 32'(kernel_busy), 32'd0);
    check_vec("rb_async_complete", 32'(kernel_complete), 32'd0);
    check_vec("rb_async_count", 32'(fifo_count), 32'd0);
    check_vec("rb_async_ready", 32'(job_ready), 32'd1);
    check_vec("rb_async_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sched_enable = 1'b1;
    repeat (10) @(negedge clk);
    check_vec("rb_no_start_count", 32'(fifo_count), 32'd0);
    expect_start(8'h01, 16'h0501);
    push_job(16'h0501);
    wait_drain();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_multi_done();
    test_enable_gate();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kernel_job_scheduler.md
KERNEL_JOB_SCHEDULER -- requirements
Module: kernel_job_scheduler

Interface
REQ-001 SHALL have parameter KERNEL_NUM, default 8: number of kernels scheduled (2..16).
REQ-002 SHALL have parameter JOB_W, default 16: job identifier width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: job queue depth (power of two).
REQ-004 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port sched_enable, input, 1: dispatch permitted when high.
REQ-007 SHALL have port job_valid, input, 1: job offered.
REQ-008 SHALL have port job_id, input, JOB_W: job identifier, qualified by job_valid.
REQ-009 SHALL have port job_ready, output, 1: queue can accept a job.
REQ-010 SHALL have port kernel_start, output, KERNEL_NUM: one-hot, one-cycle start pulse.
REQ-011 SHALL have port kernel_job_id, output, JOB_W: job id, valid while kernel_start nonzero.
REQ-012 SHALL have port kernel_done, input, KERNEL_NUM: per-kernel one-cycle done pulse.
REQ-013 SHALL have port kernel_busy, output, KERNEL_NUM: kernel running a job.
REQ-014 SHALL have port kernel_complete, output, KERNEL_NUM: level, kernel finished its last job; feeds the global interrupt slave.
REQ-015 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1: queued jobs.

Function
REQ-016 SHALL hold jobs in a FIFO; push when job_valid & job_ready; job_ready = (fifo_count < FIFO_DEPTH), combinational from registered count.
REQ-017 SHALL, on simultaneous push and pop, leave fifo_count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-018 SHALL use FSM IDLE / ARB / ISSUE: IDLE->ARB when fifo non-empty and sched_enable; ARB->ISSUE when registered kernel_busy has at least one zero bit; ARB->IDLE if sched_enable low or FIFO empty; ISSUE->ARB if FIFO still non-empty and sched_enable high, else IDLE.
REQ-019 SHALL, in ARB, select the first idle kernel searching round-robin from (last_grant+1) mod KERNEL_NUM; last_grant resets to KERNEL_NUM-1, so kernel 0 wins first.
REQ-020 SHALL, in ISSUE, assert kernel_start[g] for exactly one cycle with kernel_job_id = FIFO head, pop the FIFO, and set kernel_busy[g] and last_grant=g on the same edge.
REQ-021 SHALL dispatch at most one job per two cycles; minimum latency from push edge to kernel_start high is 2 cycles when scheduler idle.
REQ-022 SHALL clear kernel_busy[k] and set kernel_complete[k] on kernel_done[k] when kernel_busy[k]=1; kernel_done on an idle kernel SHALL be ignored.
REQ-023 SHALL clear kernel_complete[k] on the edge kernel_start[k] is issued.
REQ-024 SHALL, with multiple kernel_done bits in one cycle, process all of them on the same edge.
REQ-025 SHALL not consider a kernel freed by kernel_done eligible until the following ARB evaluation (uses registered busy).
REQ-026 SHALL, when sched_enable drops mid-operation, complete an ISSUE in progress, then go IDLE; running kernels and queued jobs are retained.
REQ-027 SHALL hold kernel_job_id at 0 when kernel_start is zero.

Reset
REQ-028 SHALL on rst_n low: FSM=IDLE, FIFO empty, fifo_count=0, job_ready=1, kernel_start=0, kernel_job_id=0, kernel_busy=0, kernel_complete=0, last_grant=KERNEL_NUM-1; in-flight jobs are discarded.

Verification
REQ-029 SHALL cover: enable=1, push id 0x0011 -> kernel_start=8'h01, kernel_job_id=0x0011 two cycles after push, kernel_busy=8'h01.
REQ-030 SHALL cover: push 9 jobs back-to-back, no done -> kernels 0..7 started in order, 9th job waits; fifo_count=1; kernel_done[3] -> 9th job starts on kernel 3.
REQ-031 SHALL cover: FIFO full (4 jobs, all kernels busy) -> job_ready=0, extra job_valid not accepted, count stays 4.
REQ-032 SHALL cover: kernel_done=8'h05 with kernels 0,2 busy -> kernel_complete=8'h05, kernel_busy bits 0,2 clear same edge; done on idle kernel 7 -> no change.
REQ-033 SHALL cover: sched_enable low with 2 queued jobs -> no kernel_start; raise enable -> dispatch resumes round-robin from last_grant+1.
REQ-034 SHALL cover: rst_n asserted while kernels busy -> all outputs at reset values asynchronously, no kernel_start after release until new push.
